// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command constants for the character-LCD controller.
package lcd_pkg;

    localparam int CNT_W = 20;

    typedef enum logic [2:0] {
        S_POWERUP, S_INIT, S_CONFIG, S_ADDR, S_MSG, S_MSG2, S_DONE
    } seqState_t;

    typedef enum logic [2:0] {
        W_IDLE, W_SETUP, W_ENABLE, W_HOLD, W_WAIT
    } wrPhase_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h28;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    // Element [i] is the i-th nibble / command sent.
    localparam logic [3:0][3:0] INIT_NIBS   = {4'h2, 4'h3, 4'h3, 4'h3};
    localparam logic [3:0][7:0] CONFIG_CMDS = {CMD_CLEAR, CMD_DISP_ON, CMD_ENTRY, CMD_FUNC_SET};

endpackage

// File: rtl/lcd_nibble_writer.sv
// One LCD bus transaction: setup, E pulse, one hold cycle, then a post-wait.
// ready is high when idle or in the final wait cycle, so nibbles chain back to back.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_EN    = 12
)(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic [3:0]       nibble,
    input  logic             rs,
    input  logic [CNT_W-1:0] postWait,
    output logic             ready,
    output logic             lcdE,
    output logic             lcdRs,
    output logic [3:0]       lcdData
);

    wrPhase_t         phase, phaseNext;
    logic [CNT_W-1:0] cnt, cntNext, waitReg;
    logic             done, accept;

    assign done   = (phase == W_HOLD && waitReg == '0) || (phase == W_WAIT && cnt == '0);
    assign ready  = (phase == W_IDLE) || done;
    assign accept = start && ready;
    assign lcdE   = (phase == W_ENABLE);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            phase   <= W_IDLE;
            cnt     <= '0;
            waitReg <= '0;
            lcdRs   <= 1'b0;
            lcdData <= '0;
        end else begin
            phase <= phaseNext;
            cnt   <= cntNext;
            if (accept) begin
                waitReg <= postWait;
                lcdRs   <= rs;
                lcdData <= nibble;
            end
        end
    end

    always_comb begin
        phaseNext = phase;
        cntNext   = cnt;
        case (phase)
            W_IDLE: ;
            W_SETUP:
                if (cnt == '0) begin
                    phaseNext = W_ENABLE;
                    cntNext   = CNT_W'(T_EN - 1);
                end else cntNext = cnt - CNT_W'(1);
            W_ENABLE:
                if (cnt == '0) phaseNext = W_HOLD;
                else cntNext = cnt - CNT_W'(1);
            W_HOLD:
                if (waitReg == '0) phaseNext = W_IDLE;
                else begin
                    phaseNext = W_WAIT;
                    cntNext   = waitReg - CNT_W'(1);
                end
            W_WAIT:
                if (cnt == '0) phaseNext = W_IDLE;
                else cntNext = cnt - CNT_W'(1);
            default: phaseNext = W_IDLE;
        endcase
        if (accept) begin
            phaseNext = W_SETUP;
            cntNext   = CNT_W'(T_SETUP - 1);
        end
    end

endmodule

// File: rtl/lcd_controller.sv
// Autonomous HD44780 4-bit sequencer: power-up, init nibbles, config, line-1 message.
// Define LCD_SECOND_LINE_EN to also write MSG2 on line 2.
module lcd_controller
    import lcd_pkg::*;
#(
    parameter int T_POWERUP = 750000,
    parameter int T_INIT1   = 205000,
    parameter int T_INIT2   = 5000,
    parameter int T_CMD     = 2000,
    parameter int T_CLEAR   = 82000,
    parameter int T_NIB_GAP = 50,
    parameter int T_SETUP   = 2,
    parameter int T_EN      = 12,
    parameter int MSG_LEN   = 5,
    parameter logic [8*MSG_LEN-1:0] MSG = "HELLO"
`ifdef LCD_SECOND_LINE_EN
    ,
    parameter int MSG2_LEN  = 5,
    parameter logic [8*MSG2_LEN-1:0] MSG2 = "WORLD"
`endif
)(
    input  logic       Clock,
    input  logic       Reset,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_StrataFlashControl,
    output logic       oLCD_ReadWrite,
    output logic [3:0] oLCD_Data
);

    seqState_t        state, stateNext, afterState;
    logic [7:0]       idx, idxNext, lastIdx, afterIdx, curByte;
    logic             half, halfNext, curRs, curValid, isByte, start, wrReady;
    logic [3:0]       curNib;
    logic [CNT_W-1:0] pwrCnt, curWait;

    assign oLCD_StrataFlashControl = 1'b1;
    assign oLCD_ReadWrite          = 1'b0;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= S_POWERUP;
            idx    <= '0;
            half   <= 1'b0;
            pwrCnt <= '0;
        end else begin
            state <= stateNext;
            idx   <= idxNext;
            half  <= halfNext;
            if (state == S_POWERUP && !curValid) pwrCnt <= pwrCnt + CNT_W'(1);
        end
    end

    // Item pointed at by (state, idx, half); the first init nibble is issued
    // from the last power-up cycle so the power-up wait is exactly T_POWERUP.
    always_comb begin
        curByte    = '0;
        curNib     = '0;
        curRs      = 1'b0;
        curWait    = '0;
        curValid   = 1'b0;
        isByte     = 1'b0;
        lastIdx    = '0;
        afterState = S_DONE;
        afterIdx   = '0;
        case (state)
            S_POWERUP: begin
                curNib   = INIT_NIBS[0];
                curWait  = CNT_W'(T_INIT1);
                curValid = (pwrCnt == CNT_W'(T_POWERUP - 1));
            end
            S_INIT: begin
                curNib   = INIT_NIBS[idx[1:0]];
                curWait  = (idx == 8'd1) ? CNT_W'(T_INIT2) : CNT_W'(T_CMD);
                curValid = 1'b1;
            end
            S_CONFIG: begin
                curByte    = CONFIG_CMDS[idx[1:0]];
                isByte     = 1'b1;
                lastIdx    = 8'd3;
                afterState = S_ADDR;
            end
            S_ADDR: begin
                curByte    = CMD_LINE1;
                isByte     = 1'b1;
                afterState = S_MSG;
            end
            S_MSG: begin
                curRs   = 1'b1;
                lastIdx = 8'(MSG_LEN - 1);
`ifdef LCD_SECOND_LINE_EN
                afterState = S_MSG2;
`else
                afterState = S_MSG;
                afterIdx   = 8'(MSG_LEN);
`endif
                if (int'(idx) < MSG_LEN) begin
                    curByte = MSG[8*(MSG_LEN-1-int'(idx)) +: 8];
                    isByte  = 1'b1;
                end
            end
`ifdef LCD_SECOND_LINE_EN
            // idx 0 is the line-2 address command, idx 1..MSG2_LEN the characters.
            S_MSG2: begin
                curRs      = (idx != 8'd0);
                lastIdx    = 8'(MSG2_LEN);
                afterState = S_MSG2;
                afterIdx   = 8'(MSG2_LEN + 1);
                if (idx == 8'd0) begin
                    curByte = CMD_LINE2;
                    isByte  = 1'b1;
                end else if (int'(idx) <= MSG2_LEN) begin
                    curByte = MSG2[8*(MSG2_LEN-int'(idx)) +: 8];
                    isByte  = 1'b1;
                end
            end
`endif
            default: ;
        endcase
        if (isByte) begin
            curValid = 1'b1;
            curNib   = half ? curByte[3:0] : curByte[7:4];
            if (!half) curWait = CNT_W'(T_NIB_GAP);
            else if (curByte == CMD_CLEAR && !curRs) curWait = CNT_W'(T_CLEAR);
            else curWait = CNT_W'(T_CMD);
        end
    end

    assign start = curValid && wrReady;

    always_comb begin
        stateNext = state;
        idxNext   = idx;
        halfNext  = half;
        if (start) begin
            if (state == S_POWERUP) begin
                stateNext = S_INIT;
                idxNext   = 8'd1;
            end else if (state == S_INIT) begin
                if (idx == 8'd3) begin
                    stateNext = S_CONFIG;
                    idxNext   = '0;
                end else idxNext = idx + 8'd1;
            end else if (!half) begin
                halfNext = 1'b1;
            end else begin
                halfNext = 1'b0;
                if (idx == lastIdx) begin
                    stateNext = afterState;
                    idxNext   = afterIdx;
                end else idxNext = idx + 8'd1;
            end
        end else if ((state == S_MSG || state == S_MSG2) && !curValid && wrReady) begin
            // Message exhausted: let the last post-wait drain, then park.
            stateNext = S_DONE;
        end
    end

    lcd_nibble_writer #(.T_SETUP(T_SETUP), .T_EN(T_EN)) uWriter (
        .Clock    (Clock),
        .Reset    (Reset),
        .start    (start),
        .nibble   (curNib),
        .rs       (curRs),
        .postWait (curWait),
        .ready    (wrReady),
        .lcdE     (oLCD_Enabled),
        .lcdRs    (oLCD_RegisterSelect),
        .lcdData  (oLCD_Data)
    );

endmodule

// File: tb/tb_lcd_controller.sv
// Bench for lcd_controller with shortened timing: expected E pulses are queued from
// tables and checked (bus value, spacing, width) as the DUT produces them.
module tb_lcd_controller;

    localparam int T_POWERUP = 20, T_INIT1 = 10, T_INIT2 = 8, T_CMD = 6;
    localparam int T_CLEAR = 9, T_NIB_GAP = 3, T_SETUP = 2, T_EN = 12;
    // rise-to-rise distance is this plus the post-wait of the earlier nibble
    localparam int RISE_BASE = T_SETUP + T_EN + 1;

    typedef struct { logic rs; logic [3:0] nib; int waitAfter; } expNib_t;
    typedef struct { logic [3:0] nib; int waitAfter; } initVec_t;
    typedef struct { logic rs; logic [7:0] b; } byteVec_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       oLCD_Enabled, oLCD_RegisterSelect, oLCD_StrataFlashControl, oLCD_ReadWrite;
    logic [3:0] oLCD_Data;

    int tests = 0, fails = 0;
    int cyc = 0, rises = 0, lastRise = 0, lastWait = 0;
    int rwsfViol = 0, stableViol = 0;
    bit sbOn = 0, haveLast = 0;
    logic       prevE = 1'b0;
    logic [4:0] prevBus = '0;
    expNib_t    sbq[$];

    lcd_controller #(
        .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_CMD(T_CMD),
        .T_CLEAR(T_CLEAR), .T_NIB_GAP(T_NIB_GAP)
    ) dut (
        .Clock                   (Clock),
        .Reset                   (Reset),
        .oLCD_Enabled            (oLCD_Enabled),
        .oLCD_RegisterSelect     (oLCD_RegisterSelect),
        .oLCD_StrataFlashControl (oLCD_StrataFlashControl),
        .oLCD_ReadWrite          (oLCD_ReadWrite),
        .oLCD_Data               (oLCD_Data)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkIdle(input string tag);
        check({tag, "_E"},    int'(oLCD_Enabled), 0);
        check({tag, "_RS"},   int'(oLCD_RegisterSelect), 0);
        check({tag, "_Data"}, int'(oLCD_Data), 0);
        check({tag, "_RW"},   int'(oLCD_ReadWrite), 0);
        check({tag, "_SF"},   int'(oLCD_StrataFlashControl), 1);
    endtask

    // Bus monitor: sampled on the falling edge.
    always @(negedge Clock) begin
        expNib_t e;
        cyc++;
        if (oLCD_ReadWrite !== 1'b0 || oLCD_StrataFlashControl !== 1'b1) rwsfViol++;
        if (oLCD_Enabled && prevE && {oLCD_RegisterSelect, oLCD_Data} != prevBus) stableViol++;
        if (oLCD_Enabled && !prevE) begin
            rises++;
            if (sbOn) begin
                if (sbq.size() == 0) begin
                    check("extra_E_pulse", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("pulse_rs", int'(oLCD_RegisterSelect), int'(e.rs));
                    check("pulse_data", int'(oLCD_Data), int'(e.nib));
                    if (haveLast) check("rise_spacing", cyc - lastRise, RISE_BASE + lastWait);
                    lastWait = e.waitAfter;
                end
                lastRise = cyc;
                haveLast = 1;
            end
        end
        if (!oLCD_Enabled && prevE && sbOn && haveLast) check("E_width", cyc - lastRise, T_EN);
        prevE   = oLCD_Enabled;
        prevBus = {oLCD_RegisterSelect, oLCD_Data};
    end

    initial begin
        initVec_t initTab[4];
        byteVec_t byteTab[$];
        string    msg;
        int       k, seen;

        initTab = '{'{nib: 4'h3, waitAfter: T_INIT1}, '{nib: 4'h3, waitAfter: T_INIT2},
                    '{nib: 4'h3, waitAfter: T_CMD},   '{nib: 4'h2, waitAfter: T_CMD}};
        byteTab.push_back('{rs: 1'b0, b: 8'h28});
        byteTab.push_back('{rs: 1'b0, b: 8'h06});
        byteTab.push_back('{rs: 1'b0, b: 8'h0C});
        byteTab.push_back('{rs: 1'b0, b: 8'h01});
        byteTab.push_back('{rs: 1'b0, b: 8'h80});
        msg = "HELLO";
        for (int i = 0; i < msg.len(); i++) byteTab.push_back('{rs: 1'b1, b: msg[i]});
`ifdef LCD_SECOND_LINE_EN
        byteTab.push_back('{rs: 1'b0, b: 8'hC0});
        msg = "WORLD";
        for (int i = 0; i < msg.len(); i++) byteTab.push_back('{rs: 1'b1, b: msg[i]});
`endif

        // Power-on reset
        repeat (3) @(posedge Clock);
        #1 checkIdle("por");
        Reset = 1'b0;

        // Let the sequence get into the init phase, then reset it mid-way
        k = 0;
        while (rises < 2 && k < 5000) begin
            @(posedge Clock);
            k++;
        end
        check("pre_reset_pulses_seen", int'(rises >= 2), 1);
        #1 Reset = 1'b1;
        @(posedge Clock);
        #1 checkIdle("mid_reset");
        @(posedge Clock);
        @(posedge Clock);

        for (int i = 0; i < 4; i++)
            sbq.push_back('{rs: 1'b0, nib: initTab[i].nib, waitAfter: initTab[i].waitAfter});
        foreach (byteTab[i]) begin
            sbq.push_back('{rs: byteTab[i].rs, nib: byteTab[i].b[7:4], waitAfter: T_NIB_GAP});
            sbq.push_back('{rs: byteTab[i].rs, nib: byteTab[i].b[3:0],
                            waitAfter: (byteTab[i].b == 8'h01 && !byteTab[i].rs) ? T_CLEAR : T_CMD});
        end
        haveLast = 0;
        sbOn     = 1;
        #1 Reset = 1'b0;

        k = 0;
        do begin
            @(posedge Clock);
            #1;
            k++;
        end while (!oLCD_Enabled && k < 200);
        check("first_rise_after_release", k, T_POWERUP + T_SETUP);

        k = 0;
        while (sbq.size() != 0 && k < 20000) begin
            @(posedge Clock);
            k++;
        end
        check("all_expected_pulses_seen", sbq.size(), 0);

        seen = rises;
        repeat (1000) @(posedge Clock);
        #1;
        check("no_pulses_when_done", rises - seen, 0);
        check("done_E_low", int'(oLCD_Enabled), 0);
        check("rw_sf_constant", rwsfViol, 0);
        check("bus_stable_while_E", stableViol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_controller.md
Name: lcd_controller

Overview:
- Autonomous write-only controller for an HD44780-compatible character LCD on a 4-bit bus, as on the Spartan-3E starter-board LCD.
- After reset it runs the power-on nibble initialisation, then the configuration commands, then writes a fixed ASCII message to line 1, then idles.
- Top-level leaf block with no host interface; its outputs drive the LCD pins directly.

Parameters:
- T_POWERUP, 750000: cycles to wait after reset before the first init nibble (15 ms at 50 MHz).
- T_INIT1, 205000: wait after init nibble 1 (4.1 ms).
- T_INIT2, 5000: wait after init nibble 2 (100 us).
- T_CMD, 2000: wait after each byte, and after init nibbles 3 and 4 (40 us).
- T_CLEAR, 82000: wait after the Clear Display byte (1.64 ms).
- T_NIB_GAP, 50: gap between the upper and lower nibble of one byte (1 us).
- T_SETUP, 2: cycles data/RS are stable before E rises.
- T_EN, 12: cycles E is held high.
- MSG, "HELLO": 8-bit ASCII string written to line 1; MSG_LEN = 5.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- oLCD_Enabled  out  1  LCD E strobe.
- oLCD_RegisterSelect  out  1  RS: 0 = command, 1 = data.
- oLCD_StrataFlashControl  out  1  SF_CE0; constant 1 so the shared flash is disabled.
- oLCD_ReadWrite  out  1  R/W; constant 0 (write only).
- oLCD_Data  out  4  LCD DB[7:4].

Behaviour:
- Reset is sampled on the rising Clock edge. While Reset is high:
  - oLCD_Enabled = 0, oLCD_RegisterSelect = 0, oLCD_Data = 0, oLCD_ReadWrite = 0, oLCD_StrataFlashControl = 1.
  - The FSM goes to POWERUP and all counters clear.
- Reset asserted mid-sequence aborts immediately. The whole sequence restarts from POWERUP after release.
- Nibble write, which is the only bus action:
  - Data and RS are driven; E = 0 for T_SETUP cycles.
  - E = 1 for T_EN cycles.
  - E = 0, with data and RS held, for 1 cycle.
  - Then the post-wait starts. Data and RS stay unchanged until the next nibble begins.
- Byte write:
  - Upper nibble, then T_NIB_GAP wait.
  - Lower nibble, then T_CMD wait, or T_CLEAR wait if the byte is 0x01.
- FSM states:
  - POWERUP: count T_POWERUP, then go to INIT.
  - INIT: RS = 0. Four single nibbles: 0x3 (wait T_INIT1), 0x3 (wait T_INIT2), 0x3 (wait T_CMD), 0x2 (wait T_CMD).
  - CONFIG: RS = 0. Bytes in order: 0x28 Function Set, 0x06 Entry Mode, 0x0C Display On, 0x01 Clear.
  - ADDR: RS = 0. Byte 0x80, which sets the DDRAM address to 0.
  - MSG: RS = 1. MSG characters from index 0 to MSG_LEN-1. The index increments after each byte's post-wait.
  - DONE: terminal state. E = 0, outputs frozen. Stays in DONE until Reset.
- Wait counters count down to 0 inclusive; a wait of N occupies exactly N cycles.
- Counters are 20 bits wide, enough for T_POWERUP. No wrap-around is permitted.

Optional Feature:
- Macro: LCD_SECOND_LINE_EN.
- Defined:
  - After MSG, write command 0xC0 (DDRAM address 0x40) with RS = 0.
  - Then write parameter MSG2 (default "WORLD", MSG2_LEN = 5) with RS = 1.
  - Then enter DONE.
- Undefined: MSG goes directly to DONE; the MSG2 logic is absent.

Decomposition:
- Package lcd_pkg:
  - FSM state enum (POWERUP, INIT, CONFIG, ADDR, MSG, MSG2, DONE).
  - Command constants: CMD_FUNC_SET = 8'h28, CMD_ENTRY = 8'h06, CMD_DISP_ON = 8'h0C, CMD_CLEAR = 8'h01, CMD_LINE1 = 8'h80, CMD_LINE2 = 8'hC0.
  - INIT nibble table.
- Sub-module lcd_nibble_writer:
  - Inputs: start, nibble, rs, post-wait count.
  - Behaviour: generates the setup/E/hold/wait timing and pulses done.
  - The top-level sequencer drives it.

Test Plan (the bench overrides timing to T_POWERUP = 20, T_INIT1 = 10, T_INIT2 = 8, T_CMD = 6, T_CLEAR = 9, T_NIB_GAP = 3):
- Reset held 3 cycles mid-sequence -> next cycle E = 0, Data = 0, RS = 0, R/W = 0, SF = 1; first E rise occurs exactly 20 + T_SETUP cycles after release.
- Init phase -> first four E pulses carry Data 3, 3, 3, 2 with RS = 0; each E-high width is 12 cycles; spacing matches T_INIT1/T_INIT2/T_CMD.
- Config phase -> nibble pairs (2,8), (0,6), (0,C), (0,1), (8,0) with RS = 0; the wait after (0,1) is 9 cycles.
- Message phase -> RS = 1 pairs (4,8), (4,5), (4,C), (4,C), (4,F), i.e. "HELLO"; no further E pulses after 1000 idle cycles.
- Throughout the run -> R/W stays 0 and SF stays 1 on every cycle; Data and RS never change while E = 1.
- LCD_SECOND_LINE_EN defined -> after "HELLO", RS = 0 pair (C,0), then RS = 1 "WORLD" pairs (5,7), (4,F), (5,2), (4,C), (4,4).
